seg7_scan: RTL and testbench

- 4-digit multiplexed 7-segment display driver, downstream of the stopwatch counter block.
- Consumes the four BCD digits (10 ms, 100 ms, 1 s, 10 s).
- Drives a common-anode display: one digit enabled at a time, with a blanking gap between digit slots to suppress ghosting.
- Provides a lap/hold freeze of the displayed value and optional leading-zero blanking of the 10 s digit.

---
 rtl/seg7_scan.sv | 92 +++++++++
 tb/tb_seg7_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode 7-segment driver with per-slot blanking,
// lap/hold freeze of the displayed value and optional leading-zero blanking.
module seg7_scan #(
  parameter int unsigned P_SCAN_CNT = 31999,
  parameter int unsigned P_BLANK    = 255,
  parameter int unsigned P_DP_DIGIT = 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [3:0] t_10ms,
  input  logic [3:0] t_100ms,
  input  logic [3:0] t_1s,
  input  logic [3:0] t_10s,
  input  logic       lap,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned LP_CW = (P_SCAN_CNT < 1) ? 1 : $clog2(P_SCAN_CNT + 1);
  localparam logic [LP_CW-1:0] LP_MAX   = LP_CW'(P_SCAN_CNT);
  localparam logic [LP_CW-1:0] LP_BLANK = LP_CW'(P_BLANK);
  localparam logic [1:0]       LP_DP    = 2'(P_DP_DIGIT);

  logic [LP_CW-1:0] r_scan_cnt;
  logic [1:0]       r_idx;
  logic             r_hold;
  logic [15:0]      r_disp;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg;
  logic             w_lz;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == LP_MAX) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // The load decision uses the pre-toggle hold state, so a lap pulse while
  // running still captures that cycle's inputs before freezing.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_hold <= 1'b0;
      r_disp <= '0;
    end else begin
      if (!r_hold) r_disp <= {t_10s, t_1s, t_100ms, t_10ms};
      if (lap)     r_hold <= ~r_hold;
    end
  end

  always_comb begin
    w_digit = r_disp[r_idx*4 +: 4];
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = 7'b0111111;
    endcase
    w_lz = (r_idx == 2'd3) && blank_lz && (w_digit == 4'd0);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else if (r_scan_cnt < LP_BLANK) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_lz ? '1 : w_seg;
      dp  <= (r_idx != LP_DP);
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized self-checking bench for seg7_scan against a slot/frame-level
// behavioural model, plus literal checks of the main display scenarios.
module tb_seg7_scan;

  localparam int SCAN  = 7;
  localparam int BLANK = 2;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  localparam logic [3:0] AN_TBL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [3:0] t_10ms = 4'd1, t_100ms = 4'd2, t_1s = 4'd3, t_10s = 4'd4;
  logic       lap = 1'b0, blank_lz = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int vectors = 0;
  int miscompares = 0;

  seg7_scan #(.P_SCAN_CNT(SCAN), .P_BLANK(BLANK), .P_DP_DIGIT(2)) dut (
    .clk(clk), .rstb(rstb), .t_10ms(t_10ms), .t_100ms(t_100ms), .t_1s(t_1s),
    .t_10s(t_10s), .lap(lap), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an));

  always #5 clk = ~clk;

  // Model: k counts clocks since reset release; slot and position follow from it.
  int         k = 0;
  bit         m_hold = 1'b0;
  logic [3:0] m_disp [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  logic       e_dp = 1'b1;

  initial forever begin
    @(posedge clk or negedge rstb);
    if (!rstb) begin
      k = 0; m_hold = 1'b0; m_disp = '{4'd0, 4'd0, 4'd0, 4'd0};
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      int pos, slot;
      logic [3:0] d;
      pos  = k % (SCAN + 1);
      slot = (k / (SCAN + 1)) % 4;
      if (pos < BLANK) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        d     = m_disp[slot];
        e_an  = AN_TBL[slot];
        e_seg = (slot == 3 && blank_lz && d == 4'd0) ? 7'h7F : SEG_TBL[d];
        e_dp  = (slot == 2) ? 1'b0 : 1'b1;
      end
      if (!m_hold) m_disp = '{t_10ms, t_100ms, t_1s, t_10s};
      if (lap) m_hold = !m_hold;
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    vectors++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
      miscompares++;
      $display("FAIL cycle t=%0t: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               $time, an, seg, dp, e_an, e_seg, e_dp);
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Wait for the start of a fresh slot showing anode pattern pat (bounded).
  task automatic wait_an(input logic [3:0] pat);
    int n = 0;
    while (an == pat && n < 100) begin @(negedge clk); n++; end
    while (an != pat && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      vectors++; miscompares++;
      $display("FAIL wait_an: an=%b never reached %b", an, pat);
    end
  endtask

  task automatic set_in(input logic [3:0] a, b, c, d);
    t_10ms = a; t_100ms = b; t_1s = c; t_10s = d;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", {3'b0, an}, 7'b0001111);
    chk("reset_seg", seg, 7'b1111111);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("blank_an", {3'b0, an}, 7'b0001111);
    @(negedge clk);
    chk("slot0_an", {3'b0, an}, 7'b0001110);
    chk("slot0_seg", seg, 7'b1111001);
    chk("slot0_dp", {6'b0, dp}, 7'd1);
    repeat (8) @(negedge clk);
    chk("slot1_seg", seg, 7'b0100100);
    repeat (8) @(negedge clk);
    chk("slot2_an", {3'b0, an}, 7'b0001011);
    chk("slot2_seg", seg, 7'b0110000);
    chk("slot2_dp", {6'b0, dp}, 7'd0);
    repeat (8) @(negedge clk);
    chk("slot3_an", {3'b0, an}, 7'b0000111);
    chk("slot3_seg", seg, 7'b0011001);

    // Hold
    set_in(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (2) @(negedge clk);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    set_in(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3 * 4 * (SCAN + 1)) @(negedge clk);
    wait_an(4'b1110); chk("hold_d0", seg, 7'b0010010);
    wait_an(4'b0111); chk("hold_d3", seg, 7'b0000000);
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
    wait_an(4'b1110); chk("release_d0", seg, 7'b1000000);

    // Leading zero and invalid BCD
    blank_lz = 1'b1;
    wait_an(4'b0111); chk("lz_an", {3'b0, an}, 7'b0000111); chk("lz_seg", seg, 7'b1111111);
    blank_lz = 1'b0;
    wait_an(4'b0111); chk("nolz_seg", seg, 7'b1000000);
    t_100ms = 4'hC;
    wait_an(4'b1101); chk("bad_bcd", seg, 7'b0111111);

    // Random
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) t_10s = 4'd0;
      lap = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
    end
    @(negedge clk);
    lap = 1'b0;

    // Asynchronous reset mid-slot at index 2
    wait_an(4'b1011);
    repeat (2) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("async_an", {3'b0, an}, 7'b0001111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_dp", {6'b0, dp}, 7'd1);
    @(negedge clk);
    set_in(4'd9, 4'd2, 4'd3, 4'd4);
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_blank", {3'b0, an}, 7'b0001111);
    @(negedge clk);
    chk("post_rst_an", {3'b0, an}, 7'b0001110);
    chk("post_rst_seg", seg, 7'b0010000);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
